// File: rtl/sort_stream_pkg.sv
// Shared types and helpers for the sort_stream_engine frame sorter.
// Holds the FSM state encoding, the counter-width helper and the padding rule.
package sort_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SORT,
        DRAIN
    } state_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pads sort to the tail: all-ones when ascending, zero when descending.
    // The caller narrows the result to its element width.
    function automatic logic [31:0] pad_val(input logic desc);
        return desc ? '0 : '1;
    endfunction

endpackage

// File: rtl/sort_stream_engine_cx.sv
// Combinational compare-exchange cell for one adjacent pair of the sort array.
// lo_out receives the min (ascending) or the max (descending).
module sort_cx #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             desc,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out
);

    logic             a_gt;
    logic [WIDTH-1:0] mn;
    logic [WIDTH-1:0] mx;

    assign a_gt   = a_in > b_in;
    assign mn     = a_gt ? b_in : a_in;
    assign mx     = a_gt ? a_in : b_in;
    assign lo_out = desc ? mx : mn;
    assign hi_out = desc ? mn : mx;

endmodule

// File: rtl/sort_stream_engine.sv
// Sequential frame sorter: loads up to DEPTH elements, runs DEPTH odd-even
// transposition passes, then streams the sorted frame out over valid/ready.
module sort_stream_engine
    import sort_stream_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_desc,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] mem   [DEPTH];
    logic [WIDTH-1:0] mem_n [DEPTH];
    logic [WIDTH-1:0] lo    [DEPTH-1];
    logic [WIDTH-1:0] hi    [DEPTH-1];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] rd_idx;
    logic             desc_q;
    logic             in_ready_q;
    logic             accept;
    logic             frame_end;
    logic             dir;
    logic             last_el;
    logic [WIDTH-1:0] pad;

    assign accept    = in_valid && in_ready_q;
    assign frame_end = accept && (in_last || count == LAST_IDX);
    // Direction is not yet latched while the first beat is being accepted.
    assign dir       = (state == IDLE) ? in_desc : desc_q;
    assign pad       = WIDTH'(pad_val(dir));
    assign last_el   = (rd_idx == count - CNT_W'(1));

    for (genvar i = 0; i < DEPTH - 1; i++) begin : g_cx
        sort_cx #(
            .WIDTH(WIDTH)
        ) u_cx (
            .a_in  (mem[i]),
            .b_in  (mem[i+1]),
            .desc  (desc_q),
            .lo_out(lo[i]),
            .hi_out(hi[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = frame_end ? SORT : LOAD;
            LOAD:    if (frame_end) state_n = SORT;
            SORT:    if (pass_cnt == LAST_IDX) state_n = DRAIN;
            DRAIN:   if (out_ready && last_el) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Even passes write back pairs starting at even slots, odd passes the rest;
    // the frame-end beat also pads every slot above it in the same edge.
    always_comb begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
            mem_n[j] = mem[j];
        end
        if (state == SORT) begin
            for (int unsigned j = 0; j < DEPTH - 1; j++) begin
                if (j[0] == pass_cnt[0]) begin
                    mem_n[j]   = lo[j];
                    mem_n[j+1] = hi[j];
                end
            end
        end else if (accept) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (j == 32'(count)) begin
                    mem_n[j] = in_data;
                end else if (frame_end && j > 32'(count)) begin
                    mem_n[j] = pad;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem[j] <= '0;
            end
            count      <= '0;
            pass_cnt   <= '0;
            rd_idx     <= '0;
            desc_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem[j] <= mem_n[j];
            end
            in_ready_q <= (state_n == IDLE) || (state_n == LOAD);
            if (accept && state == IDLE) begin
                desc_q <= in_desc;
            end
            if (accept) begin
                count <= count + CNT_W'(1);
            end
            pass_cnt <= (state == SORT) ? pass_cnt + CNT_W'(1) : '0;
            if (state == DRAIN && out_ready) begin
                if (last_el) begin
                    rd_idx <= '0;
                    count  <= '0;
                end else begin
                    rd_idx <= rd_idx + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state == DRAIN);
    assign out_data  = out_valid ? mem[rd_idx[IDX_W-1:0]] : '0;
    assign out_last  = out_valid && last_el;
    assign busy      = (state == SORT) || (state == DRAIN);

endmodule

// File: doc/sort_stream_engine.md
Name: sort_stream_engine

Overview:
- Parametrised successor to the team's 2-input max/min sorter: a sequential frame sorter.
- Accepts a frame of up to DEPTH unsigned WIDTH-bit values over a valid/ready input stream.
- Sorts the frame in place with odd-even transposition, ascending or descending per frame, then streams the result out over a valid/ready output.
- Used wherever a ranked list is needed (priority selection, median pick).

Parameters:
- WIDTH, 5, bit width of each unsigned element.
- DEPTH, 8, maximum elements per frame; must be even and ≥2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_data  input  WIDTH  input element.
- in_last  input  1  marks the final beat of the frame.
- in_desc  input  1  sort direction (1 = descending); sampled with the first beat of a frame.
- in_ready  output  1  engine accepts a beat this cycle.
- out_valid  output  1  sorted element valid.
- out_data  output  WIDTH  sorted element.
- out_last  output  1  marks the final sorted element.
- out_ready  input  1  downstream accepts the element.
- busy  output  1  high in SORT and DRAIN states.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- While rst is high:
  - State goes to IDLE.
  - All outputs are 0, including in_ready, out_valid, out_data, out_last and busy.
  - Element count and storage are cleared.
  - in_ready is registered and rises on the first clk edge after rst deasserts.
- States:
  - IDLE: in_ready = 1. A beat is accepted when in_valid and in_ready are both high. The first accepted beat latches in_desc, writes slot 0 and moves to LOAD, or straight to SORT if in_last is set.
  - LOAD: in_ready = 1. Each accepted beat writes the next slot. The frame ends on in_last, or implicitly when slot DEPTH-1 is written. At frame end, in_ready drops the same edge and the state moves to SORT.
  - SORT: exactly DEPTH cycles, no early exit. Cycle k runs one compare-exchange pass:
    - k even: pairs (0,1),(2,3),…
    - k odd: pairs (1,2),(3,4),…
    - Ascending: the lower index receives the min. Descending: the lower index receives the max.
  - DRAIN: out_valid = 1 and out_data = slot[rd_idx], starting at rd_idx = 0. The index advances on each out_valid && out_ready. out_last = 1 when rd_idx = count-1. After the last element is accepted the state goes to IDLE and in_ready = 1 on the next edge.
- Latency: if the last input beat is accepted on edge t0, out_valid rises on edge t0+DEPTH. Input-to-output is DEPTH cycles, independent of data and count.
- Short frames (count < DEPTH): unused slots are padded at frame end. The pad is all-ones for ascending and zero for descending, so pads sort to the tail. Only count elements are ever output.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable. No element is dropped or duplicated.
- No overlap: input and output phases never overlap. in_ready = 0 throughout SORT and DRAIN.
- Equal values are allowed; ordering among equal values is unobservable.
- Widths: comparisons are unsigned. The element count register is $clog2(DEPTH+1) bits; the pass counter is $clog2(DEPTH+1) bits.
- Reset mid-operation (any state): immediate return to the reset condition. No partial frame survives.

Decomposition:
- Package sort_stream_pkg:
  - state enum {IDLE, LOAD, SORT, DRAIN};
  - localparam CNT_W = $clog2(DEPTH+1), supplied via a parameterised function or per-instance localparam;
  - pad-value function pad_val(desc).
- Sub-module sort_cx: combinational compare-exchange of two WIDTH-bit values with a desc input, producing lo_out and hi_out. It is instantiated DEPTH-1 times; even and odd passes select which pairs are written back.

Test Plan (WIDTH=5, DEPTH=8):
1. Ascending full frame: in_desc=0, 8,7,6,31,0,12,7,3 with in_last on 3 → out 0,3,6,7,7,8,12,31; out_last only with 31; out_valid rises exactly 8 edges after the last-beat accept.
2. Descending full frame: same data, in_desc=1 on the first beat → 31,12,8,7,7,6,3,0.
3. Short frame and minimal frame:
   - 5,31,2 with in_last on 2, ascending → exactly 3 outputs 2,5,31, out_last on 31, no pad value emitted.
   - Single beat 17 with in_last → one output 17 with out_last=1.
4. Backpressure: frame 4,1,3,2,9,0,30,5; out_ready pattern 1,0,0,1,0,1,1,0… → each value held stable while stalled; sequence 0,1,2,3,4,5,9,30 with no drops.
5. Implicit truncation: 9 beats offered with no in_last → in_ready low after the 8th accept; 9th beat not taken; 8 outputs, out_last on the 8th.
6. Reset mid-SORT: assert rst during pass 3 → all outputs 0 immediately. After release, frame 10,2 ascending → outputs 2,10 with no stale data.
